// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with input synchroniser and a valid/ready holding register.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RS232_USB_sin,
    output logic [7:0] o_dat,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver_c;
    logic             frame_err_c;

    // Synchronise the asynchronous line; idle level is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RS232_USB_sin};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State, counters and shift register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Next-state logic: mid-bit sampling against the synchronised line.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        deliver_c   = 1'b0;
        frame_err_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        deliver_c = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_c = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register, handshake and status pulses; busy tracks the next state so it equals state != IDLE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            o_dat       <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= frame_err_c;
            o_overrun   <= 1'b0;
            o_busy      <= (state_d != S_IDLE);
            if (deliver_c) begin
                if (!o_valid || i_ready) begin
                    o_dat   <= shift_q;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed bench for the 8N1 receiver at 16 clocks per bit.
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    // Edges from the first edge after the pin falls to o_valid high:
    // 2 synchroniser + 1 IDLE->START + 8 to reach and act on the mid-start count + 9 bits of 16.
    localparam int DELIV = SYNC + 1 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       rdy;
    logic [7:0] dat;
    logic       valid;
    logic       ferr;
    logic       ovr;
    logic       busy;

    int n_checks = 0;
    int n_err    = 0;

    int         cyc       = 0;
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         vcyc      = 0;
    int         rise_cyc  = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] rx_q[$];

    int         start_cyc;
    logic       probe_valid;
    logic [7:0] probe_dat;
    int         q0, f0, o0, v0;

    always #5 clk = ~clk;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .RS232_USB_sin(sin),
        .o_dat        (dat),
        .o_valid      (valid),
        .i_ready      (rdy),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_busy       (busy)
    );

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and record of every byte the consumer accepts.
    always @(negedge clk) begin
        if (ferr) fe_cnt <= fe_cnt + 1;
        if (ovr) ov_cnt <= ov_cnt + 1;
        if (valid) vcyc <= vcyc + 1;
        if (valid && !valid_prev) rise_cyc <= cyc;
        valid_prev <= valid;
        if (valid && rdy) rx_q.push_back(dat);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame; optional ready raise, output probe and reset at given cycle offsets.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int rdy_at, input int probe_at, input int rst_at);
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == 0) start_cyc = cyc;
            if (c < CPB) sin = 1'b0;
            else if (c < 9 * CPB) sin = d[3'((c - CPB) / CPB)];
            else sin = stop;
            if (c == rdy_at) rdy = 1'b1;
            if (c == probe_at) begin
                probe_valid = valid;
                probe_dat   = dat;
            end
            if (c == rst_at) begin
                rst = 1'b1;
                tick(1);
                return;
            end
            tick(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        rdy = 1'b1;
        tick(3);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_dat", 32'(dat), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        tick(5);

        // Single byte, consumer always ready.
        q0 = rx_q.size(); v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, -1, -1, -1);
        check("t1_count", 32'(rx_q.size() - q0), 32'd1);
        check("t1_dat", 32'(rx_q[q0]), 32'hA5);
        check("t1_vcyc", 32'(vcyc - v0), 32'd1);
        check("t1_latency", 32'(rise_cyc - start_cyc), 32'(DELIV));
        check("t1_ferr", 32'(fe_cnt - f0), 32'd0);
        check("t1_ovr", 32'(ov_cnt - o0), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // Overrun: second byte dropped while the first is held.
        rdy = 1'b0;
        q0 = rx_q.size(); o0 = ov_cnt;
        send_frame(8'h3C, 1'b1, -1, -1, -1);
        send_frame(8'hC3, 1'b1, -1, -1, -1);
        check("t2_ovr", 32'(ov_cnt - o0), 32'd1);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_dat", 32'(dat), 32'h3C);
        check("t2_none_taken", 32'(rx_q.size() - q0), 32'd0);
        rdy = 1'b1;
        tick(1);
        check("t2_valid_fall", 32'(valid), 32'd0);
        check("t2_taken", 32'(rx_q[q0]), 32'h3C);

        // Framing error followed by a held-low line.
        q0 = rx_q.size(); f0 = fe_cnt;
        send_frame(8'h55, 1'b0, -1, -1, -1);
        tick(40);
        check("t3_ferr", 32'(fe_cnt - f0), 32'd1);
        check("t3_valid", 32'(valid), 32'd0);
        check("t3_busy_break", 32'(busy), 32'd1);
        sin = 1'b1;
        tick(5);
        check("t3_busy_idle", 32'(busy), 32'd0);
        send_frame(8'h0F, 1'b1, -1, -1, -1);
        check("t3_count", 32'(rx_q.size() - q0), 32'd1);
        check("t3_dat", 32'(rx_q[q0]), 32'h0F);
        check("t3_ferr_once", 32'(fe_cnt - f0), 32'd1);

        // Short low glitch on an idle line.
        q0 = rx_q.size(); f0 = fe_cnt;
        sin = 1'b0;
        tick(5);
        sin = 1'b1;
        tick(1);
        check("t4_busy_start", 32'(busy), 32'd1);
        tick(30);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valid", 32'(valid), 32'd0);
        check("t4_ferr", 32'(fe_cnt - f0), 32'd0);
        check("t4_count", 32'(rx_q.size() - q0), 32'd0);

        // Back-to-back frames; first byte consumed on the second byte's mid-stop edge.
        rdy = 1'b0;
        q0 = rx_q.size(); o0 = ov_cnt;
        send_frame(8'h00, 1'b1, -1, -1, -1);
        send_frame(8'hFF, 1'b1, DELIV - 1, DELIV, -1);
        send_frame(8'h81, 1'b1, -1, -1, -1);
        check("t5_probe_valid", 32'(probe_valid), 32'd1);
        check("t5_probe_dat", 32'(probe_dat), 32'hFF);
        check("t5_ovr", 32'(ov_cnt - o0), 32'd0);
        check("t5_count", 32'(rx_q.size() - q0), 32'd3);
        check("t5_b0", 32'(rx_q[q0]), 32'h00);
        check("t5_b1", 32'(rx_q[q0+1]), 32'hFF);
        check("t5_b2", 32'(rx_q[q0+2]), 32'h81);

        // Reset in the middle of bit 4, with a byte held in the register.
        rdy = 1'b0;
        send_frame(8'h5A, 1'b1, -1, -1, -1);
        check("t6_held_valid", 32'(valid), 32'd1);
        check("t6_held_dat", 32'(dat), 32'h5A);
        send_frame(8'hE7, 1'b1, -1, -1, CPB + 4 * CPB + CPB / 2);
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_dat", 32'(dat), 32'h00);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ferr", 32'(ferr), 32'd0);
        check("t6_rst_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        sin = 1'b1;
        rdy = 1'b1;
        tick(10);
        q0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h96, 1'b1, -1, -1, -1);
        check("t6_count", 32'(rx_q.size() - q0), 32'd1);
        check("t6_dat", 32'(rx_q[q0]), 32'h96);
        check("t6_ferr", 32'(fe_cnt - f0), 32'd0);
        check("t6_ovr", 32'(ov_cnt - o0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
